// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the loader FSM state enum and byte/word sizing.
package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/instr_mem_loader_packer.sv
// byte_packer: shifts bytes into a big-endian word and flags the 4th byte.
// Ports: clk, reset, clear, take, din -> word_valid, word.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              take,
  input  logic [BYTE_W-1:0] din,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]               cnt;
  logic [WORD_W-BYTE_W-1:0] sh;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      sh  <= '0;
    end else if (take) begin
      sh  <= {sh[WORD_W-2*BYTE_W-1:0], din};
      cnt <= cnt + 2'd1;
    end
  end

  // The word is presented together with its last byte, so the
  // FSM can latch it on the same edge as the final handshake.
  assign word       = {sh, din};
  assign word_valid = take && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: header N, N words, opt. checksum.
// Ports: start/rx_* in; rx_ready, wr_*, busy/done/error, words_loaded out. Macro: INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int SIZE   = 18,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       words_loaded
);

  state_t            state;
  logic [31:0]       n_words;
  logic              take;
  logic              go;
  logic              wv;
  logic [WORD_W-1:0] word;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
`endif

  assign take = rx_valid && rx_ready;
  assign go   = start && (state == IDLE || state == DONE || state == ERR);

  byte_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (go),
    .take       (take),
    .din        (rx_data),
    .word_valid (wv),
    .word       (word)
  );

  // words_loaded doubles as the write index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      n_words      <= '0;
      rx_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (go) begin
            state        <= HDR;
            rx_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end
        HDR: begin
          if (wv) begin
            n_words <= word;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum    <= word;
`endif
            if (word == '0) begin
              state    <= DONE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (word > 32'(SIZE)) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (wv) begin
            state    <= WRITE;
            rx_ready <= 1'b0;
            wr_en    <= 1'b1;
            wr_data  <= word;
            wr_addr  <= ADDR_W'({words_loaded[29:0], 2'b00});
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= csum ^ word;
`endif
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 32'd1;
          if (words_loaded + 32'd1 == n_words) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state    <= CHK;
            rx_ready <= 1'b1;
`else
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            state    <= DATA;
            rx_ready <= 1'b1;
          end
        end
        CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          if (wv) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (word == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Scoreboard of expected writes, checked when wr_en pulses.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] words_loaded;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_count = 0;

  instr_mem_loader #(.SIZE(18), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t e;
      wr_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got addr=%h data=%h, required none",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          n_fail++;
          $display("FAIL write got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    exp_q.delete();
    wr_count = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout got 0, required 1");
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_end();
    int guard;
    guard = 0;
    rx_valid = 1'b0;
    while (done !== 1'b1 && error !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL end_timeout got done=%b error=%b, required one set",
               done, error);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rx_ready, wr_en, busy, done, error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b, required 00000",
               {rx_ready, wr_en, busy, done, error});
    end
    n_checks++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wr got %h/%h, required 0/0", wr_addr, wr_data);
    end
    n_checks++;
    if (words_loaded !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d, required 0", words_loaded);
    end
  endtask

  task automatic test_basic();
    do_reset();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy got %b, required 1", busy);
    end
    exp_q.push_back('{addr: 32'h0, data: 32'h00011020});
    exp_q.push_back('{addr: 32'h4, data: 32'hAE010000});
    send_word(32'h00000002);
    send_word(32'h00011020);
    n_checks++;
    if (wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_wr_timing got %b, required 1", wr_en);
    end
    send_word(32'hAE010000);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_word(32'hAE011022);
`endif
    wait_end();
    n_checks++;
    if ({done, error, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_status got %b, required 100", {done, error, busy});
    end
    n_checks++;
    if (words_loaded !== 32'd2 || wr_count != 2) begin
      n_fail++;
      $display("FAIL basic_count got %0d/%0d, required 2/2",
               words_loaded, wr_count);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_pending got %0d, required 0", exp_q.size());
    end
`ifndef INSTR_LOADER_CHECKSUM_EN
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_tail got ready=%b done=%b, required 0/1",
               rx_ready, done);
    end
    rx_valid = 1'b0;
`endif
  endtask

  task automatic test_oversize();
    do_reset();
    pulse_start();
    send_word(32'h00000013);
    wait_end();
    n_checks++;
    if ({done, error, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL over_status got %b, required 010", {done, error, busy});
    end
    n_checks++;
    if (wr_count != 0 || words_loaded !== 32'd0) begin
      n_fail++;
      $display("FAIL over_writes got %0d/%0d, required 0/0",
               wr_count, words_loaded);
    end
  endtask

  task automatic test_zero();
    do_reset();
    pulse_start();
    send_word(32'h00000000);
    wait_end();
    n_checks++;
    if ({done, error, busy} !== 3'b100 || wr_count != 0) begin
      n_fail++;
      $display("FAIL zero_status got %b/%0d, required 100/0",
               {done, error, busy}, wr_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    pulse_start();
    exp_q.push_back('{addr: 32'h0, data: 32'h08000008});
    send_word(32'h00000001);
    send_byte(8'h08);
    send_byte(8'h00);
    rx_valid = 1'b0;
    rx_data  = 8'h55;
    pulse_start();
    repeat (2) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h08);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_word(32'h08000009);
`endif
    wait_end();
    n_checks++;
    if ({done, error} !== 2'b10 || wr_count != 1) begin
      n_fail++;
      $display("FAIL stall_status got %b/%0d, required 10/1",
               {done, error}, wr_count);
    end
    n_checks++;
    if (words_loaded !== 32'd1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_count got %0d/%0d, required 1/0",
               words_loaded, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    exp_q.push_back('{addr: 32'h0, data: 32'h11111111});
    exp_q.push_back('{addr: 32'h4, data: 32'h22222222});
    send_word(32'h00000003);
    send_word(32'h11111111);
    send_word(32'h22222222);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rx_ready, wr_en, busy, done, error} !== 5'b0 ||
        wr_addr !== 32'h0 || wr_data !== 32'h0 ||
        words_loaded !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset got %b %h %h %0d, required 00000 0 0 0",
               {rx_ready, wr_en, busy, done, error},
               wr_addr, wr_data, words_loaded);
    end
    reset = 1'b0;
    n_checks++;
    if (wr_count != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_writes got %0d/%0d, required 2/0",
               wr_count, exp_q.size());
    end
    @(negedge clk);
    wr_count = 0;
    pulse_start();
    exp_q.push_back('{addr: 32'h0, data: 32'h12345678});
    send_word(32'h00000001);
    send_word(32'h12345678);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_word(32'h12345679);
`endif
    wait_end();
    n_checks++;
    if (done !== 1'b1 || wr_count != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart got done=%b writes=%0d, required 1/1",
               done, wr_count);
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    pulse_start();
    exp_q.push_back('{addr: 32'h0, data: 32'h00011020});
    send_word(32'h00000001);
    send_word(32'h00011020);
    send_word(32'h00011021);
    wait_end();
    n_checks++;
    if ({done, error} !== 2'b10) begin
      n_fail++;
      $display("FAIL csum_good got %b, required 10", {done, error});
    end
    do_reset();
    pulse_start();
    exp_q.push_back('{addr: 32'h0, data: 32'h00011020});
    send_word(32'h00000001);
    send_word(32'h00011020);
    send_word(32'h00000000);
    wait_end();
    n_checks++;
    if ({done, error} !== 2'b01 || words_loaded !== 32'd1) begin
      n_fail++;
      $display("FAIL csum_bad got %b/%0d, required 01/1",
               {done, error}, words_loaded);
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_oversize();
    test_zero();
    test_stall();
    test_reset_mid();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
